// File: rtl/result_frame_tx.sv
// Result frame serializer for the Helios host byte protocol: header bytes, then per-round correction bytes.
// Optional FRAME_CHECKSUM_EN appends an XOR checksum byte after the last correction byte.
module result_frame_tx #(
    parameter int CORRECTION_BYTES = 9,
    parameter int ROUNDS           = 5,
    parameter int ROUND_AW         = 3
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic [31:0]                   iteration_count,
    input  logic [31:0]                   cycle_count,
    output logic                          corr_rd_en,
    output logic [ROUND_AW-1:0]           corr_rd_addr,
    input  logic [CORRECTION_BYTES*8-1:0] corr_rd_data,
    output logic [7:0]                    output_data,
    output logic                          output_valid,
    input  logic                          output_ready,
    output logic                          busy,
    output logic                          done
);

    localparam int IDX_W = (CORRECTION_BYTES > 1) ? $clog2(CORRECTION_BYTES) : 1;
    localparam logic [IDX_W-1:0]    LAST_IDX   = IDX_W'(CORRECTION_BYTES - 1);
    localparam logic [ROUND_AW-1:0] LAST_ROUND = ROUND_AW'(ROUNDS - 1);

    typedef enum logic [3:0] {
        IDLE,
        HDR_ITER,
        HDR_HI,
        HDR_LO,
        FETCH,
        LOAD,
        STREAM,
`ifdef FRAME_CHECKSUM_EN
        CSUM,
`endif
        DONE
    } state_t;

    state_t                        state;
    logic [15:0]                   cycle_field;
    logic [CORRECTION_BYTES*8-1:0] shift;
    logic [IDX_W-1:0]              idx;
    logic [ROUND_AW-1:0]           round;
    logic                          xfer;
`ifdef FRAME_CHECKSUM_EN
    logic [7:0]                    csum;
`endif

    function automatic logic [7:0] sat_iter(input logic [31:0] v);
        return (v > 32'd255) ? 8'hFF : v[7:0];
    endfunction

    function automatic logic [15:0] sat_cycle(input logic [31:0] v);
        return (v > 32'd65535) ? 16'hFFFF : v[15:0];
    endfunction

    assign xfer = output_valid && output_ready;

    // All outputs are registered: each transition loads the values the next state presents.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            output_valid <= 1'b0;
            output_data  <= '0;
            corr_rd_en   <= 1'b0;
            corr_rd_addr <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            round        <= '0;
            idx          <= '0;
        end else begin
`ifdef FRAME_CHECKSUM_EN
            if (xfer) begin
                csum <= csum ^ output_data;
            end
`endif
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        cycle_field  <= sat_cycle(cycle_count);
                        output_data  <= sat_iter(iteration_count);
                        output_valid <= 1'b1;
                        busy         <= 1'b1;
                        round        <= '0;
`ifdef FRAME_CHECKSUM_EN
                        csum         <= 8'h00;
`endif
                        state        <= HDR_ITER;
                    end
                end
                HDR_ITER: begin
                    if (xfer) begin
                        output_data <= cycle_field[15:8];
                        state       <= HDR_HI;
                    end
                end
                HDR_HI: begin
                    if (xfer) begin
                        output_data <= cycle_field[7:0];
                        state       <= HDR_LO;
                    end
                end
                HDR_LO: begin
                    if (xfer) begin
                        output_valid <= 1'b0;
                        corr_rd_en   <= 1'b1;
                        corr_rd_addr <= round;
                        state        <= FETCH;
                    end
                end
                FETCH: begin
                    corr_rd_en <= 1'b0;
                    state      <= LOAD;
                end
                LOAD: begin
                    // Read data arrives the cycle after the strobe, i.e. now.
                    shift        <= corr_rd_data;
                    idx          <= '0;
                    output_data  <= corr_rd_data[7:0];
                    output_valid <= 1'b1;
                    state        <= STREAM;
                end
                STREAM: begin
                    if (xfer) begin
                        if (idx != LAST_IDX) begin
                            idx         <= idx + IDX_W'(1);
                            output_data <= shift[8*(int'(idx) + 1) +: 8];
                        end else if (round != LAST_ROUND) begin
                            round        <= round + ROUND_AW'(1);
                            corr_rd_addr <= round + ROUND_AW'(1);
                            corr_rd_en   <= 1'b1;
                            output_valid <= 1'b0;
                            state        <= FETCH;
                        end else begin
`ifdef FRAME_CHECKSUM_EN
                            // Fold in the byte being accepted right now.
                            output_data <= csum ^ output_data;
                            state       <= CSUM;
`else
                            output_valid <= 1'b0;
                            busy         <= 1'b0;
                            done         <= 1'b1;
                            state        <= DONE;
`endif
                        end
                    end
                end
`ifdef FRAME_CHECKSUM_EN
                CSUM: begin
                    if (xfer) begin
                        output_valid <= 1'b0;
                        busy         <= 1'b0;
                        done         <= 1'b1;
                        state        <= DONE;
                    end
                end
`endif
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
